// File: rtl/event_arbiter.sv
// event_arbiter: round-robin share of one event filter between NUM_SRC tiles.
// One event is latched, held stable for HOLD_CYCLES, then a one-cycle blank gap follows.
module event_arb_lane #(
  parameter int IDX     = 0,
  parameter int COORD_W = 2,
  parameter int IDW     = 2
) (
  input  logic               valid,
  input  logic [IDW-1:0]     rr_ptr,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] t,
  input  logic [COORD_W-1:0] p,
  output logic               req_hi,
  output logic [4*COORD_W-1:0] evt
);
  localparam logic [IDW-1:0] IDX_V = IDW'(IDX);

  // Requests at or above the pointer win over the wrapped-around ones.
  assign req_hi = valid && (IDX_V >= rr_ptr);
  assign evt    = {x, y, t, p};
endmodule

module event_arbiter #(
  parameter int NUM_SRC     = 4,
  parameter int COORD_W     = 2,
  parameter int HOLD_CYCLES = 5,
  localparam int IDW        = $clog2(NUM_SRC)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC*COORD_W-1:0] src_x,
  input  logic [NUM_SRC*COORD_W-1:0] src_y,
  input  logic [NUM_SRC*COORD_W-1:0] src_t,
  input  logic [NUM_SRC*COORD_W-1:0] src_p,
  output logic [NUM_SRC-1:0]         src_ack,
  output logic [COORD_W-1:0]         f_x,
  output logic [COORD_W-1:0]         f_y,
  output logic [COORD_W-1:0]         f_t,
  output logic [COORD_W-1:0]         f_p,
  output logic                       f_active,
  output logic [IDW-1:0]             grant_id,
  output logic [7:0]                 grant_cnt
);
  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] t;
    logic [COORD_W-1:0] p;
  } evt_t;

  state_t                              state, state_nxt;
  logic [IDW-1:0]                      rr_ptr, ptr_nxt, sel;
  logic [HCW-1:0]                      hold_cnt;
  logic [NUM_SRC-1:0]                  req_hi;
  logic [NUM_SRC-1:0][4*COORD_W-1:0]   lane_evt;
  evt_t                                sel_evt;
  logic                                any_req, grant, rel;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    event_arb_lane #(.IDX(i), .COORD_W(COORD_W), .IDW(IDW)) u_lane (
      .valid  (src_valid[i]),
      .rr_ptr (rr_ptr),
      .x      (src_x[i*COORD_W +: COORD_W]),
      .y      (src_y[i*COORD_W +: COORD_W]),
      .t      (src_t[i*COORD_W +: COORD_W]),
      .p      (src_p[i*COORD_W +: COORD_W]),
      .req_hi (req_hi[i]),
      .evt    (lane_evt[i])
    );
  end

  assign any_req = |src_valid;

  // Lowest set bit of the masked requests, else lowest of all requests.
  always_comb begin
    sel = '0;
    for (int i = NUM_SRC-1; i >= 0; i--)
      if (src_valid[i]) sel = IDW'(i);
    for (int i = NUM_SRC-1; i >= 0; i--)
      if (req_hi[i]) sel = IDW'(i);
  end

  assign sel_evt = evt_t'(lane_evt[sel]);
  assign ptr_nxt = (grant_id == IDW'(NUM_SRC-1)) ? '0 : grant_id + IDW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    rel       = 1'b0;
    case (state)
      IDLE: if (any_req) begin
        state_nxt = HOLD;
        grant     = 1'b1;
      end
      HOLD: if (hold_cnt == '0) begin
        state_nxt = GAP;
        rel       = 1'b1;
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_ack   <= '0;
      f_x       <= '0;
      f_y       <= '0;
      f_t       <= '0;
      f_p       <= '0;
      f_active  <= 1'b0;
      grant_id  <= '0;
      grant_cnt <= '0;
      rr_ptr    <= '0;
      hold_cnt  <= '0;
    end else begin
      src_ack <= '0;
      if (grant) begin
        src_ack   <= NUM_SRC'(1) << sel;
        f_x       <= sel_evt.x;
        f_y       <= sel_evt.y;
        f_t       <= sel_evt.t;
        f_p       <= sel_evt.p;
        f_active  <= 1'b1;
        grant_id  <= sel;
        grant_cnt <= grant_cnt + 8'd1;
        hold_cnt  <= HCW'(HOLD_CYCLES-1);
      end else if (rel) begin
        f_x      <= '0;
        f_y      <= '0;
        f_t      <= '0;
        f_p      <= '0;
        f_active <= 1'b0;
        rr_ptr   <= ptr_nxt;
      end else if (state == HOLD) begin
        hold_cnt <= hold_cnt - HCW'(1);
      end
    end
  end
endmodule

// File: doc/event_arbiter.md
# event_arbiter

Round-robin scheduler that shares one event filter instance between several event sources (sensor tiles). It accepts one pending event at a time, latches it, and presents it to the filter with stable x/y/t/p for a programmable hold window, which the filter needs to confirm polarity stability. Afterwards it drives a one-cycle blank gap so consecutive events are separated. It sits between the tile request buses and the filter inputs, and also provides a grant counter for debug.

## Interface

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8)
- COORD_W, 2, width of each x, y, t, p field
- HOLD_CYCLES, 5, cycles each event is held on the filter inputs (>=1)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- src_valid  in  NUM_SRC  per-source event pending
- src_x  in  NUM_SRC*COORD_W  packed x, source i at [i*COORD_W +: COORD_W]
- src_y  in  NUM_SRC*COORD_W  packed y, same packing
- src_t  in  NUM_SRC*COORD_W  packed t, same packing
- src_p  in  NUM_SRC*COORD_W  packed p, same packing
- src_ack  out  NUM_SRC  one-hot, one-cycle pulse: event consumed
- f_x, f_y, f_t, f_p  out  COORD_W each  registered event to filter
- f_active  out  1  high while an event is being held
- grant_id  out  clog2(NUM_SRC)  index of source currently or last granted
- grant_cnt  out  8  total grants, wraps 255->0

## Operation

- Reset (asynchronous, rst_n low): state=IDLE, rr_ptr=0, and all outputs are 0. This covers src_ack, f_*, f_active, grant_id and grant_cnt.
- FSM states: IDLE, HOLD, GAP.
- IDLE:
  - If no src_valid bit is set, stay in IDLE with all f_* = 0.
  - Otherwise, select g as the first set bit scanning rr_ptr, rr_ptr+1, … modulo NUM_SRC.
  - On the next edge: latch source g's fields into f_x/f_y/f_t/f_p, set src_ack[g]=1, set f_active=1, grant_id=g, grant_cnt+=1 (mod 256), hold_cnt=HOLD_CYCLES-1, and go to HOLD.
- HOLD:
  - src_ack returns to 0 after one cycle. f_* stay frozen; source inputs are ignored, including src_valid drop or data change.
  - If hold_cnt==0: f_active<=0, f_*<=0, rr_ptr<=(grant_id+1) mod NUM_SRC, go to GAP.
  - Otherwise, decrement hold_cnt.
- GAP: one cycle with f_active=0 and f_*=0. Go to IDLE unconditionally.
- Arithmetic:
  - hold_cnt width is clog2(HOLD_CYCLES) with a minimum of 1.
  - rr_ptr wraps from NUM_SRC-1 to 0.
  - grant_cnt wraps silently.
- Source protocol: a source holds src_valid and its fields stable until it sees src_ack. It may present its next event on the cycle after the ack.
- Fairness: a just-served source has the lowest priority at the next arbitration. Any source with valid held is served within NUM_SRC grants.
- Reset mid-HOLD or mid-GAP aborts the event immediately. No ack is repeated, and arbitration restarts from source 0.

## Timing

- Arbitration in IDLE is combinational. All outputs are registered.
- Edge E0 samples src_valid in IDLE. From E0 onward, src_ack is high for exactly one cycle, and f_active/f_* are valid for exactly HOLD_CYCLES cycles.
- Then 1 GAP cycle, then 1 IDLE cycle before the next grant can land.
- Sustained throughput: one event per HOLD_CYCLES+2 cycles (7 at default).
- Latency from src_valid high (IDLE, no contention) to f_active high: 1 cycle.
- A src_valid that rises during HOLD or GAP waits for the next IDLE. No request is lost while valid is held.

## Test plan

- **Reset values:** assert rst_n=0 asynchronously between edges → all outputs are 0 immediately. After release with no valid, outputs stay 0 for 20 cycles.
- **Single source:** src_valid=4'b0100, src2 fields x=3, y=1, t=2, p=1 → 1 cycle later src_ack=4'b0100 for 1 cycle. f_x=3, f_y=1, f_t=2, f_p=1 with f_active=1 for exactly 5 cycles, then 1 zero cycle. grant_id=2, grant_cnt=1.
- **Round-robin:** all four valid continuously → grant order 0,1,2,3,0, one grant every 7 cycles. Each src_ack is a single-cycle pulse.
- **Input change during hold:** src0 x changes 1→2 and src_valid drops during HOLD → f_x stays 1 for the full 5 cycles, and no second ack is issued.
- **Reset mid-HOLD:** pull rst_n low in hold cycle 3 with rr_ptr=2 → f_active drops immediately. After release with src1 and src3 valid, src1 is granted first.
- **Counter wrap:** run 256 grants → grant_cnt wraps to 0. Also build with HOLD_CYCLES=1 → f_active is high for 1 cycle and the period is 3 cycles.
